// File: rtl/cache_line_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_line_sequencer
// Purpose  : Direct-mapped write-back/write-allocate cache control engine with
//            word-by-word write-back and refill over a narrow memory port.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_sequencer #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int c_off_w = $clog2(LINE_WORDS);
    localparam int c_idx_w = $clog2(LINES);
    localparam int c_tag_w = ADDR_W - c_idx_w - c_off_w;
    localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_miss;
    logic [c_off_w-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic [LINES-1:0]    r_valid;
    logic [LINES-1:0]    r_dirty;
    logic [c_tag_w-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0]   r_data [LINES*LINE_WORDS];

    logic [c_tag_w-1:0]  w_tag;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_off_w-1:0]  w_off;
    logic                w_hit;
    logic                w_beat_done;
    logic                w_last;

    assign w_tag       = r_addr[ADDR_W-1 -: c_tag_w];
    assign w_idx       = r_addr[c_off_w +: c_idx_w];
    assign w_off       = r_addr[c_off_w-1:0];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Acks outside the two memory phases never count as a beat.
    assign w_beat_done = mem_ack && (r_state == S_WRITEBACK || r_state == S_REFILL);
    assign w_last      = (r_cnt == c_last_beat);
    assign cpu_rdata   = r_rdata;
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cpu_ready = 1'b0;
        cpu_hit   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit)                               w_next = S_RESP;
                else if (r_valid[w_idx] && r_dirty[w_idx]) w_next = S_WRITEBACK;
                else                                     w_next = S_REFILL;
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[w_idx], w_idx, r_cnt};
                mem_wdata = r_data[{w_idx, r_cnt}];
                if (w_beat_done && w_last) w_next = S_REFILL;
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_idx, r_cnt};
                if (w_beat_done && w_last) w_next = S_LOOKUP;
            end
            S_RESP: begin
                cpu_ready = 1'b1;
                cpu_hit   = !r_miss;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_miss  <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < LINES; i++) r_tag[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_we    <= cpu_we;
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_miss  <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_we) r_dirty[w_idx] <= 1'b1;
                        else      r_rdata <= r_data[{w_idx, w_off}];
                    end else begin
                        r_miss <= 1'b1;
                        r_cnt  <= '0;
                    end
                end
                S_WRITEBACK: begin
                    if (w_beat_done) r_cnt <= r_cnt + 1'b1;
                end
                S_REFILL: begin
                    if (w_beat_done) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_tag[w_idx]   <= w_tag;
                            r_valid[w_idx] <= 1'b1;
                            r_dirty[w_idx] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Data storage carries no reset; valid bits gate its use.
    always_ff @(posedge clk) begin
        if (r_state == S_LOOKUP && w_hit && r_we)
            r_data[{w_idx, w_off}] <= r_wdata;
        else if (w_beat_done && r_state == S_REFILL)
            r_data[{w_idx, r_cnt}] <= mem_rdata;
    end

endmodule
`default_nettype wire
